// File: rtl/pll_reset_sequencer_if.sv
// PLL lock / reset-sequencer signal bundle.
// The master drives lock and clear; the slave is the sequencer that produces the reset.
interface pll_reset_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             locked;
  logic             clear_count;
  logic             reset_out_n;
  logic             ready;
  logic             lock_lost;
  logic [CNT_W-1:0] loss_count;

  modport master (
    output locked, clear_count,
    input  reset_out_n, ready, lock_lost, loss_count
  );

  modport slave (
    input  locked, clear_count,
    output reset_out_n, ready, lock_lost, loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock for STABLE_CYCLES+HOLD_CYCLES before releasing a synchronous reset.
// Re-asserts the reset on loss of lock and keeps a saturating count of losses from RUN.
module pll_reset_sequencer #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned CNT_W         = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  pll_reset_sequencer_if.slave bus
);

  localparam int unsigned MAXC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             sync_1;
  logic             locked_s;
  logic             rst_out_q;
  logic             ready_q;
  logic             lock_lost_q;
  logic [CNT_W-1:0] loss_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_1   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_1   <= bus.locked;
      locked_s <= sync_1;
    end
  end

  // reset_out_n/ready are set on the edge that enters RUN and cleared on the edge that leaves it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      rst_out_q   <= 1'b0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_q      <= '0;
    end else begin
      lock_lost_q <= 1'b0;
      if (bus.clear_count) begin
        loss_q <= '0;
      end
      case (state)
        WAIT_LOCK: begin
          cnt <= '0;
          if (locked_s) begin
            state <= STABLE;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            rst_out_q   <= 1'b0;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b1;
            // A simultaneous clear takes priority over the increment.
            if (!bus.clear_count && (loss_q != '1)) begin
              loss_q <= loss_q + 1'b1;
            end
          end
        end
        default: begin
          state     <= WAIT_LOCK;
          cnt       <= '0;
          rst_out_q <= 1'b0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reset_out_n = rst_out_q;
  assign bus.ready       = ready_q;
  assign bus.lock_lost   = lock_lost_q;
  assign bus.loss_count  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboarded bench for pll_reset_sequencer with STABLE_CYCLES=4, HOLD_CYCLES=2, CNT_W=2.
// Stimulus queues expected ready transitions; a negedge monitor matches them as they appear.
module tb_pll_reset_sequencer;

  localparam int CNT_MAX = 3;

  typedef struct {
    bit rise;
    int edge_no;
    bit lost;
    int cnt;
  } ev_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   edge_n  = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;
  ev_t  q[$];
  logic prev_ready = 1'b0;

  pll_reset_sequencer_if #(.CNT_W(2)) bus ();

  pll_reset_sequencer #(
    .STABLE_CYCLES(4),
    .HOLD_CYCLES  (2),
    .CNT_W        (2)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_ev(input bit rise, input int edge_no, input bit lost, input int cnt);
    ev_t e;
    e.rise    = rise;
    e.edge_no = edge_no;
    e.lost    = lost;
    e.cnt     = cnt;
    q.push_back(e);
  endtask

  // Drop lock from RUN; the fall is expected 3 edges after the drop.
  task automatic drop_lock(input bit clr);
    int k;
    k = edge_n;
    bus.locked = 1'b0;
    if (clr) exp_cnt = 0;
    else if (exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
    push_ev(1'b0, k + 3, 1'b1, exp_cnt);
    step(2);
    bus.clear_count = clr;
    step(1);
    bus.clear_count = 1'b0;
  endtask

  task automatic raise_lock();
    int k;
    k = edge_n;
    bus.locked = 1'b1;
    push_ev(1'b1, k + 9, 1'b0, exp_cnt);
  endtask

  always @(negedge clock) begin
    ev_t e;
    if (bus.ready !== prev_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready_change ready=%b expected=no_change t=%0t", bus.ready, $time);
      end else begin
        e = q.pop_front();
        if (bus.ready !== e.rise || (e.edge_no >= 0 && edge_n != e.edge_no) ||
            bus.lock_lost !== e.lost || bus.loss_count !== 2'(e.cnt)) begin
          errors++;
          $display("FAIL ready_event ready=%b/%b edge=%0d/%0d lock_lost=%b/%b loss_count=%0d/%0d (actual/expected)",
                   bus.ready, e.rise, edge_n, e.edge_no, bus.lock_lost, e.lost, bus.loss_count, e.cnt);
        end
      end
    end else begin
      checks++;
      if (bus.lock_lost !== 1'b0) begin
        errors++;
        $display("FAIL stray_lock_lost actual=%b expected=0 t=%0t", bus.lock_lost, $time);
      end
    end
    checks++;
    if (bus.reset_out_n !== bus.ready) begin
      errors++;
      $display("FAIL rst_vs_ready reset_out_n=%b expected=%b t=%0t", bus.reset_out_n, bus.ready, $time);
    end
    prev_ready = bus.ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.locked      = 1'b0;
    bus.clear_count = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_reset_out_n", 32'(bus.reset_out_n), 0);
    check("rst_ready",       32'(bus.ready),       0);
    check("rst_lock_lost",   32'(bus.lock_lost),   0);
    check("rst_loss_count",  32'(bus.loss_count),  0);
    step(2);
    #2 reset_n = 1'b1;
    step(1);

    // Lock qualification
    k = edge_n;
    raise_lock();
    step(8);
    check("t1_ready_edge8",       32'(bus.ready),       0);
    check("t1_reset_out_n_edge8", 32'(bus.reset_out_n), 0);
    step(1);
    check("t1_ready_edge9", 32'(bus.ready), 1);
    step(2);

    // Loss in RUN, then re-lock
    drop_lock(1'b0);
    raise_lock();
    step(9);
    check("t2_loss_count", 32'(bus.loss_count), 1);
    check("t2_ready",      32'(bus.ready),      1);

    // One-cycle glitch during STABLE
    drop_lock(1'b0);
    k = edge_n;
    bus.locked = 1'b1;
    step(4);
    bus.locked = 1'b0;
    step(1);
    bus.locked = 1'b1;
    push_ev(1'b1, k + 14, 1'b0, exp_cnt);
    step(9);
    check("t3_stable_loss_count", 32'(bus.loss_count), 2);
    check("t3_stable_ready",      32'(bus.ready),      1);

    // One-cycle glitch during HOLD
    drop_lock(1'b0);
    k = edge_n;
    bus.locked = 1'b1;
    step(6);
    bus.locked = 1'b0;
    step(1);
    bus.locked = 1'b1;
    push_ev(1'b1, k + 16, 1'b0, exp_cnt);
    step(9);
    check("t3_hold_loss_count", 32'(bus.loss_count), 3);
    check("t3_hold_ready",      32'(bus.ready),      1);

    // Clear, saturation, clear coinciding with increment
    bus.clear_count = 1'b1;
    step(1);
    bus.clear_count = 1'b0;
    exp_cnt = 0;
    check("t4_clear", 32'(bus.loss_count), 0);
    for (int i = 0; i < 5; i++) begin
      drop_lock(1'b0);
      check("t4_sat_count", 32'(bus.loss_count), (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
      raise_lock();
      step(9);
    end
    drop_lock(1'b1);
    check("t4_clear_wins", 32'(bus.loss_count), 0);
    raise_lock();
    step(9);

    // Asynchronous reset pulse in RUN
    push_ev(1'b0, -1, 1'b0, 0);
    exp_cnt = 0;
    bus.clear_count = 1'b0;
    drop_lock_free: begin end
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_reset_out_n", 32'(bus.reset_out_n), 0);
    check("t5_async_ready",       32'(bus.ready),       0);
    check("t5_async_loss_count",  32'(bus.loss_count),  0);
    #1 reset_n = 1'b1;
    k = edge_n;
    push_ev(1'b1, k + 9, 1'b0, 0);
    step(1);
    step(8);
    check("t5_ready_after", 32'(bus.ready), 1);

    // Lock already high at reset release
    push_ev(1'b0, -1, 1'b0, 0);
    #2 reset_n = 1'b0;
    bus.locked = 1'b0;
    step(3);
    bus.locked = 1'b1;
    step(1);
    check("t6_in_reset_ready", 32'(bus.ready), 0);
    #2 reset_n = 1'b1;
    k = edge_n;
    push_ev(1'b1, k + 9, 1'b0, 0);
    step(9);
    check("t6_ready_after", 32'(bus.ready), 1);

    step(3);
    check("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
